// File: rtl/sand_brush_queue_if.sv
// sand_brush_queue_if: HPS register bus, display swap and brush stream bundled for sand_brush_queue
interface sand_brush_queue_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10,
    parameter int R_W = 3,
    parameter int T_W = 2
);
    logic              kernel_chipselect;
    logic              kernel_write;
    logic              kernel_read;
    logic [2:0]        kernel_address;
    logic [31:0]       kernel_writedata;
    logic [31:0]       kernel_readdata;
    logic              screen_swap;
    logic [31:0]       screen_a_ptr;
    logic [31:0]       screen_b_ptr;
    logic              brush_valid;
    logic              brush_ready;
    logic [X_W-1:0]    brush_x;
    logic [Y_W-1:0]    brush_y;
    logic [R_W-1:0]    brush_radius;
    logic [T_W-1:0]    brush_t;

    modport slave (
        input  kernel_chipselect, kernel_write, kernel_read, kernel_address, kernel_writedata,
        input  screen_swap, brush_ready,
        output kernel_readdata, screen_a_ptr, screen_b_ptr,
        output brush_valid, brush_x, brush_y, brush_radius, brush_t
    );

    modport master (
        output kernel_chipselect, kernel_write, kernel_read, kernel_address, kernel_writedata,
        output screen_swap, brush_ready,
        input  kernel_readdata, screen_a_ptr, screen_b_ptr,
        input  brush_valid, brush_x, brush_y, brush_radius, brush_t
    );
endinterface

// File: rtl/sand_brush_queue.sv
// sand_brush_queue: HPS-staged brush commands queued into a FIFO, plus double-buffer screen pointers
module sand_brush_queue #(
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int R_W   = 3,
    parameter int T_W   = 2,
    parameter int DEPTH = 8
) (
    input logic            clock,
    input logic            reset,
    sand_brush_queue_if.slave bus
);
    localparam int A_W = $clog2(DEPTH);
    localparam int C_W = A_W + 1;
    localparam int E_W = X_W + Y_W + R_W + T_W;

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [R_W-1:0] r_r;
    logic [T_W-1:0] r_t;
    logic [E_W-1:0] r_mem [DEPTH];
    logic [A_W-1:0] r_wptr, r_rptr;
    logic [C_W-1:0] r_count;
    logic           r_ovf;
    logic [31:0]    r_rdata, r_a, r_b;

    logic        w_wr, w_rd, w_commit, w_pop, w_push, w_full, w_empty, w_clr;
    logic [31:0] w_status, w_rdata;

    assign w_wr     = bus.kernel_chipselect & bus.kernel_write;
    assign w_rd     = bus.kernel_chipselect & bus.kernel_read;
    assign w_commit = w_wr && bus.kernel_address == 3'd4;
    assign w_clr    = w_wr && bus.kernel_address == 3'd5 && bus.kernel_writedata[2];
    assign w_empty  = r_count == '0;
    assign w_full   = r_count == C_W'(DEPTH);
    assign w_pop    = bus.brush_valid & bus.brush_ready;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign w_push   = w_commit && (!w_full || w_pop);
    assign w_status = {{(24 - C_W){1'b0}}, r_count, 5'd0, r_ovf, w_full, w_empty};

    assign bus.brush_valid = !w_empty;
    assign {bus.brush_x, bus.brush_y, bus.brush_radius, bus.brush_t} = r_mem[r_rptr];
    assign bus.kernel_readdata = r_rdata;
    assign bus.screen_a_ptr    = r_a;
    assign bus.screen_b_ptr    = r_b;

    always_comb begin
        w_rdata = '0;
        case (bus.kernel_address)
            3'd0: w_rdata = 32'(r_x);
            3'd1: w_rdata = 32'(r_y);
            3'd2: w_rdata = 32'(r_r);
            3'd3: w_rdata = 32'(r_t);
            3'd5: w_rdata = w_status;
            3'd6: w_rdata = r_a;
            3'd7: w_rdata = r_b;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= {r_x, r_y, r_r, r_t};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_r     <= '0;
            r_t     <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            if (w_wr && bus.kernel_address == 3'd0) r_x <= bus.kernel_writedata[X_W-1:0];
            if (w_wr && bus.kernel_address == 3'd1) r_y <= bus.kernel_writedata[Y_W-1:0];
            if (w_wr && bus.kernel_address == 3'd2) r_r <= bus.kernel_writedata[R_W-1:0];
            if (w_wr && bus.kernel_address == 3'd3) r_t <= bus.kernel_writedata[T_W-1:0];
            if (w_push) r_wptr <= r_wptr + A_W'(1);
            if (w_pop) r_rptr <= r_rptr + A_W'(1);
            r_count <= r_count + C_W'(w_push) - C_W'(w_pop);
            r_ovf   <= (w_commit && !w_push) || (r_ovf && !w_clr);
            if (w_rd) r_rdata <= w_rdata;
            // swap first, then a same-cycle pointer write overrides its target
            r_a <= (w_wr && bus.kernel_address == 3'd6) ? bus.kernel_writedata : bus.screen_swap ? r_b : r_a;
            r_b <= (w_wr && bus.kernel_address == 3'd7) ? bus.kernel_writedata : bus.screen_swap ? r_a : r_b;
        end
    end
endmodule
